// File: rtl/div_pkg.sv
// Shared constants and types for the multi-cycle divider beside the E-stage ALU.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 5;

  // Funct field codes, shared with the main decoder
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  typedef struct packed {
    logic neg_quot;
    logic neg_rem;
    logic div0;
  } div_flags_t;

endpackage

// File: rtl/div_ctrl_if.sv
// E-stage request / HI-LO result bundle between the pipeline and the divider.
interface div_ctrl_if #(
  parameter int unsigned WIDTH = div_pkg::DIV_WIDTH
) ();

  logic             startE;
  logic             signedE;
  logic [WIDTH-1:0] opaE;
  logic [WIDTH-1:0] opbE;
  logic             cancel;
  logic             holdE;
  logic             stall_div;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  modport master (
    output startE, signedE, opaE, opbE, cancel, holdE,
    input  stall_div, busy, result_valid, quot, rem
  );

  modport slave (
    input  startE, signedE, opaE, opbE, cancel, holdE,
    output stall_div, busy, result_valid, quot, rem
  );

endinterface

// File: rtl/div_core.sv
// Restoring shift-subtract datapath: one quotient bit per step, next values exposed
// so the controller can capture the final iteration's result on the same edge.
module div_core
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_nxt_o,
  output logic [WIDTH-1:0] rem_nxt_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;

  // Dividend register doubles as the quotient shift register
  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    qbit    = ~trial[WIDTH];
    rem_d   = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_d   = {dvd_q[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      dvd_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= rem_d;
      dvd_q <= dvd_d;
    end
  end

  assign quot_nxt_o = dvd_d;
  assign rem_nxt_o  = rem_d;

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU controller: stalls the pipeline while div_core iterates, applies sign
// fixup and divide-by-zero override, and holds the result until E advances.
module div_ctrl
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic     clk,
  input  logic     rst,
  div_ctrl_if.slave bus
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  div_flags_t       flags_q, flags_d;
  logic [WIDTH-1:0] opa_raw_q, opa_raw_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic             load_c;
  logic             step_c;
  logic [WIDTH-1:0] opa_abs_c;
  logic [WIDTH-1:0] opb_abs_c;
  logic [WIDTH-1:0] core_quot;
  logic [WIDTH-1:0] core_rem;
  logic [WIDTH-1:0] quot_fix_c;
  logic [WIDTH-1:0] rem_fix_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      flags_q   <= '0;
      opa_raw_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flags_q   <= flags_d;
      opa_raw_q <= opa_raw_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
    end
  end

  // Next state; cancel overrides every transition and suppresses datapath updates
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    unique case (state_q)
      DIV_IDLE: begin
        if (bus.startE) begin
          state_d = DIV_BUSY;
          load_c  = 1'b1;
        end
      end
      DIV_BUSY: begin
        step_c = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (!bus.holdE) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (bus.cancel) begin
      state_d = DIV_IDLE;
      load_c  = 1'b0;
      step_c  = 1'b0;
    end
  end

  // Operand conditioning and per-operation context
  always_comb begin
    opa_abs_c = (bus.signedE && bus.opaE[WIDTH-1]) ? (WIDTH'(0) - bus.opaE) : bus.opaE;
    opb_abs_c = (bus.signedE && bus.opbE[WIDTH-1]) ? (WIDTH'(0) - bus.opbE) : bus.opbE;
    cnt_d     = cnt_q;
    flags_d   = flags_q;
    opa_raw_d = opa_raw_q;
    if (load_c) begin
      cnt_d            = '0;
      flags_d.neg_quot = bus.signedE & (bus.opaE[WIDTH-1] ^ bus.opbE[WIDTH-1]);
      flags_d.neg_rem  = bus.signedE & bus.opaE[WIDTH-1];
      flags_d.div0     = (bus.opbE == '0);
      opa_raw_d        = bus.opaE;
    end else if (step_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  div_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_c),
    .step_i     (step_c),
    .dividend_i (opa_abs_c),
    .divisor_i  (opb_abs_c),
    .quot_nxt_o (core_quot),
    .rem_nxt_o  (core_rem)
  );

  // Sign fixup; a zero divisor returns all-ones and the untouched dividend
  always_comb begin
    if (flags_q.div0) begin
      quot_fix_c = '1;
      rem_fix_c  = opa_raw_q;
    end else begin
      quot_fix_c = flags_q.neg_quot ? (WIDTH'(0) - core_quot) : core_quot;
      rem_fix_c  = flags_q.neg_rem  ? (WIDTH'(0) - core_rem)  : core_rem;
    end
  end

  // Result registers load on the final iteration and read as zero outside DONE
  always_comb begin
    quot_d = quot_q;
    rem_d  = rem_q;
    if (step_c && (state_d == DIV_DONE)) begin
      quot_d = quot_fix_c;
      rem_d  = rem_fix_c;
    end else if (state_d != DIV_DONE) begin
      quot_d = '0;
      rem_d  = '0;
    end
  end

  assign bus.stall_div    = !bus.cancel &&
                            (((state_q == DIV_IDLE) && bus.startE) || (state_q == DIV_BUSY));
  assign bus.busy         = (state_q != DIV_IDLE);
  assign bus.result_valid = (state_q == DIV_DONE) && !bus.cancel;
  assign bus.quot         = quot_q;
  assign bus.rem          = rem_q;

endmodule
